// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier arbiter slice.
// Holds the sequencer state encoding, default widths and a clog2 helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } booth_state_e;

  localparam int DEF_OP_W  = 5;
  localparam int DEF_RES_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// Produces a one-hot grant plus the winner's index.
module booth_rr_arb
  import booth_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one fixed-latency Booth multiplier among NUM_REQ requesters:
// round-robin accept, one-cycle start pulse, timed capture, valid/ready response.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int MUL_LAT = 6
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*OP_W-1:0]   req_m,
  input  logic [NUM_REQ*OP_W-1:0]   req_q,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RES_W-1:0]          rsp_result,
  input  logic                      rsp_ready,
  output logic                      mul_start,
  output logic [OP_W-1:0]           mul_m,
  output logic [OP_W-1:0]           mul_q,
  input  logic [RES_W-1:0]          mul_result,
  output logic                      busy
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  booth_state_e       state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               accept;
  logic               wait_done;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    op_m_q;
  logic [OP_W-1:0]    op_q_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [RES_W-1:0]   rsp_result_q;

  booth_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    wait_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          wait_done = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by n_rst so the grant also reads 0 while reset is held.
  assign req_ready  = (state_q == IDLE && n_rst) ? grant : '0;
  assign mul_start  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign mul_m      = op_m_q;
  assign mul_q      = op_q_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (state_q == ISSUE) cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      if (wait_done) rsp_valid_q <= 1'b1;
      else if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  // Accept edge: operands are visible on mul_m/mul_q, so they clear with reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_m_q       <= '0;
      op_q_q       <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (accept) begin
        op_m_q <= req_m[int'(grant_idx)*OP_W +: OP_W];
        op_q_q <= req_q[int'(grant_idx)*OP_W +: OP_W];
      end
      if (wait_done) begin
        rsp_result_q <= mul_result;
        rsp_id_q     <= id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) id_q <= grant_idx;
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: cycle-indexed behavioural model checked every
// cycle, plus directed vectors with hand-computed products and grant orders.
module tb_booth_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int OP_W    = 5;
  localparam int RES_W   = 8;
  localparam int MUL_LAT = 6;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_m;
  logic [NUM_REQ*OP_W-1:0] req_q;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [RES_W-1:0]        rsp_result;
  logic                    rsp_ready;
  logic                    mul_start;
  logic [OP_W-1:0]         mul_m;
  logic [OP_W-1:0]         mul_q;
  logic [RES_W-1:0]        mul_result;
  logic                    busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OP_W    (OP_W),
    .RES_W   (RES_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_m      (req_m),
    .req_q      (req_q),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .mul_start  (mul_start),
    .mul_m      (mul_m),
    .mul_q      (mul_q),
    .mul_result (mul_result),
    .busy       (busy)
  );

  function automatic logic [RES_W-1:0] prod(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return RES_W'(ia * ib);
  endfunction

  function automatic int winner(input logic [NUM_REQ-1:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // Multiplier stand-in: product is on mul_result only in the cycle MUL_LAT after start.
  int               mcnt = 0;
  logic [RES_W-1:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt  <= 1;
      mprod <= prod(mul_m, mul_q);
    end else if (mcnt == MUL_LAT) mcnt <= 0;
    else if (mcnt != 0) mcnt <= mcnt + 1;
  end
  assign mul_result = (mcnt == MUL_LAT) ? mprod : 8'hA5;

  // Model: one operation occupies cycles accept..handshake; outputs follow from
  // the cycle offset k since accept.
  int            cyc = 0;
  int            m_acc = 0;
  int            m_ptr = 0;
  int            m_id = 0;
  bit            m_active = 1'b0;
  logic [OP_W-1:0] m_om = '0;
  logic [OP_W-1:0] m_oq = '0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_active <= 1'b0;
      m_ptr    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!m_active) begin
        if (winner(req_valid, m_ptr) >= 0) begin
          m_active <= 1'b1;
          m_acc    <= cyc;
          m_id     <= winner(req_valid, m_ptr);
          m_om     <= req_m[winner(req_valid, m_ptr)*OP_W +: OP_W];
          m_oq     <= req_q[winner(req_valid, m_ptr)*OP_W +: OP_W];
          m_ptr    <= (winner(req_valid, m_ptr) + 1) % NUM_REQ;
        end
      end else if ((cyc - m_acc) >= MUL_LAT + 2 && rsp_ready) begin
        m_active <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    int k;
    int w;
    logic [NUM_REQ-1:0] er;
    if (!n_rst) begin
      chk("m_reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_result, mul_start,
                                  mul_m, mul_q, busy}), 32'd0);
    end else begin
      k  = cyc - m_acc;
      w  = winner(req_valid, m_ptr);
      er = (!m_active && w >= 0) ? NUM_REQ'(1 << w) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(er));
      chk("m_busy", 32'(busy), 32'(m_active));
      chk("m_mul_start", 32'(mul_start), 32'(m_active && k == 1));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_active && k >= MUL_LAT + 2));
      if (m_active && k >= 1) begin
        chk("m_mul_m", 32'(mul_m), 32'(m_om));
        chk("m_mul_q", 32'(mul_q), 32'(m_oq));
      end
      if (m_active && k >= MUL_LAT + 2) begin
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_result", 32'(rsp_result), 32'(prod(m_om, m_oq)));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic negc();
    @(negedge clk);
    model_check();
  endtask

  task automatic set_ops(input int idx, input logic [OP_W-1:0] m, input logic [OP_W-1:0] q);
    req_m[idx*OP_W +: OP_W] = m;
    req_q[idx*OP_W +: OP_W] = q;
  endtask

  task automatic run_one(input int idx, input logic [OP_W-1:0] m, input logic [OP_W-1:0] q,
                         input logic [RES_W-1:0] exp, input logic [NUM_REQ-1:0] extra,
                         input bit scramble);
    int n;
    tick();
    req_valid = extra | NUM_REQ'(1 << idx);
    set_ops(idx, m, q);
    negc();
    chk("grant", 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    if (scramble) begin
      req_m = ~req_m;
      req_q = req_q ^ 20'h5A5A5;
    end
    negc();
    chk("start_pulse", 32'(mul_start), 32'd1);
    chk("start_m", 32'(mul_m), 32'(m));
    chk("start_q", 32'(mul_q), 32'(q));
    n = 0;
    do begin
      tick();
      negc();
      n++;
    end while (!rsp_valid && n < 20);
    chk("rsp_latency", 32'(n), 32'd7);
    chk("rsp_id", 32'(rsp_id), 32'(idx));
    chk("rsp_result", 32'(rsp_result), 32'(exp));
  endtask

  int               rr_grant[5];
  int               rr_id[5];
  logic [RES_W-1:0] rr_res[5];
  int               rr_ng, rr_nr, rr_lows;
  int               exp_order[5] = '{0, 1, 2, 3, 0};
  logic [RES_W-1:0] exp_rr_res[5] = '{8'h02, 8'h09, 8'hF4, 8'hF1, 8'h02};

  task automatic rr_sample();
    if (req_ready != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && rr_ng < 5) rr_grant[rr_ng] = i;
      end
      rr_ng++;
    end
    if (!busy) rr_lows++;
    if (rsp_valid && rr_nr < 5) begin
      rr_id[rr_nr]  = int'(rsp_id);
      rr_res[rr_nr] = rsp_result;
      rr_nr++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    req_valid = 4'b0001;
    req_m     = '0;
    req_q     = '0;
    rsp_ready = 1'b1;
    n_rst     = 1'b0;
    negc();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    req_valid = '0;
    n_rst     = 1'b1;
    negc();

    run_one(0, 5'd3, 5'd4, 8'h0C, 4'b0000, 1'b0);
    run_one(2, 5'b11101, 5'd5, 8'hF1, 4'b0000, 1'b0);
    run_one(3, 5'd7, 5'd9, 8'h3F, 4'b0000, 1'b0);

    tick();
    req_valid = 4'b1111;
    set_ops(0, 5'd1, 5'd2);
    set_ops(1, 5'd3, 5'd3);
    set_ops(2, 5'b11110, 5'd6);
    set_ops(3, 5'd15, 5'b11111);
    rr_ng = 0; rr_nr = 0; rr_lows = 0; n = 0;
    negc();
    rr_sample();
    while (rr_nr < 5 && n < 80) begin
      tick();
      negc();
      rr_sample();
      n++;
    end
    tick();
    req_valid = '0;
    negc();
    chk("rr_responses", 32'(rr_nr), 32'd5);
    chk("rr_grants", 32'(rr_ng), 32'd5);
    chk("rr_busy_low", 32'(rr_lows), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_order", 32'(rr_grant[i]), 32'(exp_order[i]));
      chk("rr_rsp_id", 32'(rr_id[i]), 32'(exp_order[i]));
      chk("rr_rsp_result", 32'(rr_res[i]), 32'(exp_rr_res[i]));
    end

    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    set_ops(1, 5'd4, 5'd4);
    set_ops(2, 5'd2, 5'b11100);
    negc();
    chk("bp_grant", 32'(req_ready), 32'b0010);
    n = 0;
    do begin
      tick();
      negc();
      n++;
    end while (!rsp_valid && n < 20);
    chk("bp_latency", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_result", 32'(rsp_result), 32'h10);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
      if (i == 4) rsp_ready = 1'b1;
      negc();
    end
    chk("bp_last_valid", 32'(rsp_valid), 32'd1);
    tick();
    negc();
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    negc();
    n = 0;
    do begin
      tick();
      negc();
      n++;
    end while (!rsp_valid && n < 20);
    chk("bp2_latency", 32'(n), 32'd7);
    chk("bp2_rsp_id", 32'(rsp_id), 32'd2);
    chk("bp2_rsp_result", 32'(rsp_result), 32'hF8);

    run_one(3, 5'd6, 5'b11110, 8'hF4, 4'b0000, 1'b1);

    tick();
    req_valid = 4'b0001;
    set_ops(0, 5'd5, 5'd5);
    negc();
    chk("rw_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    negc();
    for (int i = 0; i < 3; i++) begin
      tick();
      negc();
    end
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_result, mul_start,
                               mul_m, mul_q}), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    negc();
    for (int i = 0; i < 3; i++) begin
      tick();
      negc();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    n_rst = 1'b1;
    negc();
    run_one(0, 5'd2, 5'd3, 8'h06, 4'b1000, 1'b0);

    tick();
    negc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Booth multiplier among NUM_REQ requesters. It accepts an operand pair from one requester per operation and pulses the multiplier start for one cycle. It waits a fixed MUL_LAT cycles, captures the product, and returns it with the requester ID over a valid/ready response port. It sits between client blocks and the multiplier, and is the multiplier's only driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_W, 5, operand width (multiplicand M, multiplier Q)
RES_W, 8, product width returned by the multiplier
MUL_LAT, 6, cycles from the mul_start cycle to the cycle whose closing edge samples mul_result (>=1)

Ports:
clk  in  1  clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_m  in  NUM_REQ*OP_W  multiplicands, requester i at [i*OP_W +: OP_W]
req_q  in  NUM_REQ*OP_W  multipliers, same packing
req_ready  out  NUM_REQ  one-hot accept, combinational
rsp_valid  out  1  response valid
rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the response
rsp_result  out  RES_W  product
rsp_ready  in  1  response consumer ready
mul_start  out  1  one-cycle start pulse to the multiplier
mul_m  out  OP_W  operand M to the multiplier
mul_q  out  OP_W  operand Q to the multiplier
mul_result  in  RES_W  multiplier product
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, n_rst=0):
  - FSM to IDLE; RR pointer so requester 0 has top priority; wait counter 0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_result, mul_start, mul_m, mul_q, busy.
  - Reset mid-operation drops the in-flight operation silently. No response is produced, and mul_start stays low.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, the winner is the first set bit searching upward from pointer, wrapping at NUM_REQ.
  - req_ready[winner]=1 in the same cycle, combinationally from req_valid and pointer. All other req_ready bits are 0.
  - At the clock edge: latch the winner's M/Q into the operand regs and its index into the id reg. Pointer becomes winner+1 mod NUM_REQ. Go to ISSUE.
  - With no req_valid: stay in IDLE and leave the pointer unchanged.
- ISSUE:
  - mul_start=1 for exactly this cycle; mul_m/mul_q come from the operand regs.
  - Counter cleared to 0. Go to WAIT.
- WAIT:
  - Counter increments each cycle; mul_m/mul_q are held stable.
  - When counter==MUL_LAT-1, the closing edge captures mul_result into rsp_result and the id reg into rsp_id, then goes to RESP.
  - WAIT therefore lasts exactly MUL_LAT cycles.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_result stable until the cycle rsp_valid&&rsp_ready.
  - On handshake, go to IDLE. rsp_valid is registered and drops the next cycle.
- Latency: accept at cycle T, mul_start at T+1, rsp_valid first high at T+MUL_LAT+2. Minimum period per operation is MUL_LAT+3 cycles.
- req_ready is 0 in every state except IDLE; requests arriving during an operation wait. A requester that deasserts req_valid before its grant has no effect.
- Operands are sampled only at the accept edge; later changes on req_m/req_q are ignored.
- rsp_ready held high in RESP gives a one-cycle response. rsp_ready while not in RESP is ignored.
- rsp_result and rsp_id hold their last values outside RESP; they are not cleared.
- Counter width is clog2(MUL_LAT+1) and it never wraps.
- Product sign and width semantics belong to the multiplier; this block passes the RES_W bits through unmodified.

Decomposition:
- Shared package booth_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - default OP_W=5 and RES_W=8 constants;
  - a clog2 helper function.
- One sub-module, booth_rr_arb: combinational one-hot grant from req_valid and pointer, plus a grant-index output.
  - The pointer register stays in the top level.

Test Plan:
- Single request: requester 0, M=3, Q=4, MUL_LAT=6, bench multiplier model with 6-cycle latency.
  - req_ready[0] is high in the request cycle; mul_start is a single pulse one cycle later.
  - rsp_valid is high 8 cycles after accept, with rsp_id=0 and rsp_result=8'h0C.
- Signed operands: M=5'b11101 (-3), Q=5 → rsp_result=8'hF1 (-15), rsp_id=requester index.
- Round-robin: req_valid=4'b1111 held with distinct operands per requester.
  - Grant order is 0,1,2,3,0 and each rsp_id matches its grant.
  - There is no double grant, and busy stays high between back-to-back operations except one IDLE cycle each.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_id and rsp_result stay stable, and req_ready stays 0 despite a pending req_valid.
  - A new accept happens only after the response handshake.
- Reset mid-WAIT: assert n_rst low at counter==3.
  - All outputs read 0 immediately (async) and no response appears.
  - After release, requester 0 has priority again.
- Operand stability: change req_m/req_q after the accept edge → mul_m/mul_q keep the latched values through WAIT, and the product matches the latched pair.
